// File: rtl/sha1_core.sv
// sha1_core -- SHA-1 compression engine with internal chaining state.
//
// A 512-bit block arrives as 16 big-endian words over a valid/ready stream.
// The core then runs the 80 rounds, UNROLL rounds per clock, and adds the
// result into its own H registers so multi-block messages chain internally.
// Padding is the caller's job.
//
// Parameters:
//   UNROLL      rounds per clock; one of 1, 2, 4, 5, 8, 10, 16, 20
// Ports:
//   clk, rst    clock; asynchronous active-high reset (H and a..e -> IV)
//   start       begin a block (sampled in IDLE only)
//   first       with start: 1 = new message (H <= IV), 0 = chain onto H
//   word        message word W[t], big-endian
//   word_valid  word qualifier
//   word_ready  core accepts a word this cycle (LOAD only)
//   busy        high in every state except IDLE
//   done        one-cycle pulse; digest has just been updated
//   h_in        external initial H (only with SHA1_CORE_MIDSTATE_EN)
//   digest      {H0,H1,H2,H3,H4}
//
// Build option: define SHA1_CORE_MIDSTATE_EN to add h_in; start with
// first=1 then loads H and a..e from h_in instead of IV.
module sha1_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first,
    input  logic [31:0]  word,
    input  logic         word_valid,
    output logic         word_ready,
    output logic         busy,
    output logic         done,
`ifdef SHA1_CORE_MIDSTATE_EN
    input  logic [159:0] h_in,
`endif
    output logic [159:0] digest
);

    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [6:0]   STEP   = 7'(UNROLL);
    localparam logic [6:0]   LAST_T = 7'(80 - UNROLL);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
              UNROLL == 8 || UNROLL == 10 || UNROLL == 16 || UNROLL == 20)) begin : g_bad_unroll
            $error("sha1_core: UNROLL must be one of 1,2,4,5,8,10,16,20");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;

    state_t       state, state_n;
    logic [31:0]  h [5];
    logic [31:0]  a, b, c, d, e;
    logic [31:0]  w [16];      // w[0] is W[t] for the current round
    logic [6:0]   cnt;         // word count in LOAD, round index t in ROUND
    logic [159:0] init_h;

`ifdef SHA1_CORE_MIDSTATE_EN
    assign init_h = h_in;
`else
    assign init_h = IV;
`endif

    assign digest = {h[0], h[1], h[2], h[3], h[4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // word_ready and busy decode registered state only.
    always_comb begin
        state_n    = state;
        word_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid && cnt == 7'd15) state_n = ROUND;
            end
            ROUND:   if (cnt == LAST_T) state_n = UPDATE;
            UPDATE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // UNROLL chained rounds; the schedule window slides one word per round,
    // producing W[t+16] from taps at t+13, t+8, t+2 and t.
    logic [31:0] ra, rb, rc, rd, re, rf, rk, rtmp, wnew;
    logic [31:0] rw [16];
    logic [6:0]  rt;

    always_comb begin
        ra = a; rb = b; rc = c; rd = d; re = e;
        rw = w;
        rf = '0; rk = '0; rtmp = '0; wnew = '0; rt = cnt;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            rt = cnt + 7'(j);
            if (rt < 7'd20) begin
                rf = (rb & rc) | (~rb & rd);              rk = 32'h5a827999;
            end else if (rt < 7'd40) begin
                rf = rb ^ rc ^ rd;                        rk = 32'h6ed9eba1;
            end else if (rt < 7'd60) begin
                rf = (rb & rc) | (rb & rd) | (rc & rd);   rk = 32'h8f1bbcdc;
            end else begin
                rf = rb ^ rc ^ rd;                        rk = 32'hca62c1d6;
            end
            rtmp = {ra[26:0], ra[31:27]} + rf + re + rk + rw[0];
            re = rd;
            rd = rc;
            rc = {rb[1:0], rb[31:2]};
            rb = ra;
            ra = rtmp;
            wnew = rw[13] ^ rw[8] ^ rw[2] ^ rw[0];
            for (int unsigned k = 0; k < 15; k++) rw[k] = rw[k + 1];
            rw[15] = {wnew[30:0], wnew[31]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h    <= '{IV[159:128], IV[127:96], IV[95:64], IV[63:32], IV[31:0]};
            a    <= IV[159:128];
            b    <= IV[127:96];
            c    <= IV[95:64];
            d    <= IV[63:32];
            e    <= IV[31:0];
            w    <= '{default: '0};
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    if (first) begin
                        h <= '{init_h[159:128], init_h[127:96], init_h[95:64],
                               init_h[63:32], init_h[31:0]};
                        a <= init_h[159:128];
                        b <= init_h[127:96];
                        c <= init_h[95:64];
                        d <= init_h[63:32];
                        e <= init_h[31:0];
                    end else begin
                        a <= h[0];
                        b <= h[1];
                        c <= h[2];
                        d <= h[3];
                        e <= h[4];
                    end
                end
                LOAD: if (word_valid) begin
                    for (int unsigned k = 0; k < 15; k++) w[k] <= w[k + 1];
                    w[15] <= word;
                    cnt   <= (cnt == 7'd15) ? '0 : cnt + 7'd1;
                end
                ROUND: begin
                    a   <= ra;
                    b   <= rb;
                    c   <= rc;
                    d   <= rd;
                    e   <= re;
                    w   <= rw;
                    cnt <= cnt + STEP;
                end
                UPDATE: begin
                    h[0] <= h[0] + a;
                    h[1] <= h[1] + b;
                    h[2] <= h[2] + c;
                    h[3] <= h[3] + d;
                    h[4] <= h[4] + e;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
